// File: rtl/flash_ctrl_pkg.sv
// Shared state encoding, default timing and byte-lane constants for the
// Wishbone-to-parallel-NOR flash controller.
package flash_ctrl_pkg;

   localparam int RD_WAIT_DEF    = 7;
   localparam int WE_PULSE_DEF   = 3;
   localparam int RST_CYCLES_DEF = 25;

   localparam logic [3:0] SEL_HI = 4'b1100;
   localparam logic [3:0] SEL_LO = 4'b0011;

   typedef enum logic [2:0] {
      RST_HOLD,
      IDLE,
      RD_HI,
      RD_LO,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE
   } flash_state_t;

   // A flash write moves exactly one 16-bit half of the Wishbone word.
   function automatic logic is_legal_write_sel(input logic [3:0] sel);
      return (sel == SEL_HI) || (sel == SEL_LO);
   endfunction

endpackage

// File: rtl/flash_ry_sync.sv
// Two-flop synchronizer bringing the flash ready/busy pin into the clk domain.
module flash_ry_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta     <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/flash_wb_ctrl.sv
// Wishbone classic slave driving a 16-bit NOR flash: 32-bit reads as two
// big-endian halves, 16-bit half-word writes, and a ready/busy status register.
module flash_wb_ctrl
   import flash_ctrl_pkg::*;
#(
   parameter int RD_WAIT    = RD_WAIT_DEF,
   parameter int WE_PULSE   = WE_PULSE_DEF,
   parameter int RST_CYCLES = RST_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic [21:0] flash_addr,
   input  logic [15:0] flash_dq_i,
   output logic [15:0] flash_dq_o,
   output logic        flash_dq_oe,
   output logic        flash_ce_n,
   output logic        flash_oe_n,
   output logic        flash_we_n,
   output logic        flash_reset_n,
   output logic        flash_wp_n,
   output logic        flash_byte_n,
   input  logic        flash_ry
);

   flash_state_t state;
   logic [7:0]   cnt;
   logic [20:0]  word_q;
   logic         aborted;
   logic         ry_sync;
   logic         term_ok;
   logic         unused_adr_bits;

   assign flash_wp_n      = 1'b1;
   assign flash_byte_n    = 1'b1;
   assign unused_adr_bits = ^wb_adr_i[1:0];
   assign term_ok         = !aborted && wb_cyc_i;

   flash_ry_sync u_ry_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (flash_ry),
      .sync_out (ry_sync)
   );

   // One FSM with a shared down-counter. A master that drops cyc mid-access
   // still lets the flash cycle finish; only the termination is withheld.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RST_HOLD;
         cnt           <= 8'(RST_CYCLES - 1);
         word_q        <= '0;
         aborted       <= 1'b0;
         flash_reset_n <= 1'b0;
         flash_ce_n    <= 1'b1;
         flash_oe_n    <= 1'b1;
         flash_we_n    <= 1'b1;
         flash_dq_oe   <= 1'b0;
         flash_dq_o    <= '0;
         flash_addr    <= '0;
         wb_dat_o      <= '0;
         wb_ack_o      <= 1'b0;
         wb_err_o      <= 1'b0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         if (state inside {RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD} && !wb_cyc_i)
            aborted <= 1'b1;

         case (state)
            RST_HOLD: begin
               if (cnt == 8'd0) begin
                  state         <= IDLE;
                  flash_reset_n <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end

            IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  aborted <= 1'b0;
                  word_q  <= wb_adr_i[22:2];
                  if (wb_adr_i[23]) begin
                     state    <= DONE;
                     wb_ack_o <= 1'b1;
                     if (!wb_we_i)
                        wb_dat_o <= {31'b0, ry_sync};
                  end else if (!wb_we_i) begin
                     state      <= RD_HI;
                     cnt        <= 8'(RD_WAIT - 1);
                     flash_addr <= {wb_adr_i[22:2], 1'b0};
                     flash_ce_n <= 1'b0;
                     flash_oe_n <= 1'b0;
                  end else if (is_legal_write_sel(wb_sel_i)) begin
                     state       <= WR_SETUP;
                     flash_addr  <= {wb_adr_i[22:2], wb_sel_i == SEL_LO};
                     flash_dq_o  <= (wb_sel_i == SEL_HI) ? wb_dat_i[31:16] : wb_dat_i[15:0];
                     flash_ce_n  <= 1'b0;
                     flash_dq_oe <= 1'b1;
                  end else begin
                     state    <= DONE;
                     wb_err_o <= 1'b1;
                  end
               end
            end

            RD_HI: begin
               if (cnt == 8'd0) begin
                  wb_dat_o[31:16] <= flash_dq_i;
                  flash_addr      <= {word_q, 1'b1};
                  cnt             <= 8'(RD_WAIT - 1);
                  state           <= RD_LO;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end

            RD_LO: begin
               if (cnt == 8'd0) begin
                  wb_dat_o[15:0] <= flash_dq_i;
                  flash_ce_n     <= 1'b1;
                  flash_oe_n     <= 1'b1;
                  wb_ack_o       <= term_ok;
                  state          <= DONE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end

            WR_SETUP: begin
               flash_we_n <= 1'b0;
               cnt        <= 8'(WE_PULSE - 1);
               state      <= WR_PULSE;
            end

            WR_PULSE: begin
               if (cnt == 8'd0) begin
                  flash_we_n <= 1'b1;
                  state      <= WR_HOLD;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end

            WR_HOLD: begin
               flash_ce_n  <= 1'b1;
               flash_dq_oe <= 1'b0;
               wb_ack_o    <= term_ok;
               state       <= DONE;
            end

            DONE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_wb_ctrl.sv
// Directed bench for flash_wb_ctrl: reset hold, reads, writes, error,
// status register, cyc drop and mid-access reset, with a simple flash model.
module tb_flash_wb_ctrl;

   logic        clk;
   logic        rst;
   logic [23:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic [21:0] flash_addr;
   logic [15:0] flash_dq_i;
   logic [15:0] flash_dq_o;
   logic        flash_dq_oe;
   logic        flash_ce_n;
   logic        flash_oe_n;
   logic        flash_we_n;
   logic        flash_reset_n;
   logic        flash_wp_n;
   logic        flash_byte_n;
   logic        flash_ry;

   int compared   = 0;
   int mismatched = 0;
   int overlap    = 0;

   int ack_cycle, err_cycle, ack_count, err_count;
   int ce_low, oe_low, we_low;
   logic [31:0] got_dat;
   logic [21:0] hist_addr  [0:31];
   logic [15:0] hist_dq_o  [0:31];
   logic        hist_ce_n  [0:31];
   logic        hist_oe_n  [0:31];
   logic        hist_we_n  [0:31];
   logic        hist_dq_oe [0:31];

   flash_wb_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .wb_adr_i      (wb_adr_i),
      .wb_dat_i      (wb_dat_i),
      .wb_dat_o      (wb_dat_o),
      .wb_sel_i      (wb_sel_i),
      .wb_we_i       (wb_we_i),
      .wb_cyc_i      (wb_cyc_i),
      .wb_stb_i      (wb_stb_i),
      .wb_ack_o      (wb_ack_o),
      .wb_err_o      (wb_err_o),
      .flash_addr    (flash_addr),
      .flash_dq_i    (flash_dq_i),
      .flash_dq_o    (flash_dq_o),
      .flash_dq_oe   (flash_dq_oe),
      .flash_ce_n    (flash_ce_n),
      .flash_oe_n    (flash_oe_n),
      .flash_we_n    (flash_we_n),
      .flash_reset_n (flash_reset_n),
      .flash_wp_n    (flash_wp_n),
      .flash_byte_n  (flash_byte_n),
      .flash_ry      (flash_ry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flash contents: words 8/9 fixed, every other word is 0xC000 | addr[13:0].
   assign flash_dq_i = (flash_addr == 22'd8) ? 16'h1234 :
                       (flash_addr == 22'd9) ? 16'hABCD :
                       {2'b11, flash_addr[13:0]};

   always @(negedge clk) begin
      if (!flash_oe_n && !flash_we_n) overlap++;
      if (flash_dq_oe && !flash_oe_n) overlap++;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One Wishbone transaction: drive after an idle cycle, record pins each
   // cycle, drop the request on termination or at drop_at.
   task automatic applyStimulus(input logic [23:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic we,
                                input int drop_at, input int budget);
      @(negedge clk);
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      ack_cycle = 0; err_cycle = 0; ack_count = 0; err_count = 0;
      ce_low = 0; oe_low = 0; we_low = 0; got_dat = '0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         hist_addr[k]  = flash_addr;
         hist_dq_o[k]  = flash_dq_o;
         hist_ce_n[k]  = flash_ce_n;
         hist_oe_n[k]  = flash_oe_n;
         hist_we_n[k]  = flash_we_n;
         hist_dq_oe[k] = flash_dq_oe;
         if (!flash_ce_n) ce_low++;
         if (!flash_oe_n) oe_low++;
         if (!flash_we_n) we_low++;
         if (wb_ack_o) begin
            ack_count++;
            if (ack_cycle == 0) begin
               ack_cycle = k;
               got_dat   = wb_dat_o;
            end
         end
         if (wb_err_o) begin
            err_count++;
            if (err_cycle == 0) err_cycle = k;
         end
         if (wb_ack_o || wb_err_o || k == drop_at) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
         end
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
      wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      flash_ry = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_reset_n", 32'(flash_reset_n), 32'd0);
      checkOutput("rst_strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n, flash_dq_oe}), 32'b1110);
      checkOutput("rst_addr", 32'(flash_addr), 32'd0);
      checkOutput("rst_dat_o", wb_dat_o, 32'd0);
      checkOutput("rst_ack_err", 32'({wb_ack_o, wb_err_o}), 32'd0);
      checkOutput("tie_wp_byte", 32'({flash_wp_n, flash_byte_n}), 32'b11);

      // Reset hold of 25 cycles with a status read pending throughout
      @(posedge clk);
      #1;
      rst = 1'b0;
      wb_adr_i = 24'h800000;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         checkOutput($sformatf("hold_reset_n_%0d", k), 32'(flash_reset_n), 32'd0);
         checkOutput($sformatf("hold_pins_%0d", k),
                     32'({flash_ce_n, flash_oe_n, flash_we_n, flash_dq_oe, wb_ack_o, wb_err_o}),
                     32'b111000);
      end
      @(negedge clk);
      checkOutput("hold_release", 32'(flash_reset_n), 32'd1);
      checkOutput("hold_no_ack_yet", 32'(wb_ack_o), 32'd0);
      @(negedge clk);
      checkOutput("held_req_ack", 32'(wb_ack_o), 32'd1);
      checkOutput("held_req_dat", wb_dat_o, 32'd0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;

      // Read 0x000010 -> words 8,9
      applyStimulus(24'h000010, 32'h0, 4'b1111, 1'b0, 0, 20);
      checkOutput("rd_ack_cycle", 32'(ack_cycle), 32'd15);
      checkOutput("rd_ack_count", 32'(ack_count), 32'd1);
      checkOutput("rd_err_count", 32'(err_count), 32'd0);
      checkOutput("rd_data", got_dat, 32'h1234ABCD);
      checkOutput("rd_addr_hi", 32'(hist_addr[7]), 32'd8);
      checkOutput("rd_addr_lo", 32'(hist_addr[8]), 32'd9);
      checkOutput("rd_oe_low", 32'(oe_low), 32'd14);
      checkOutput("rd_we_low", 32'(we_low), 32'd0);
      checkOutput("rd_ce_end", 32'({hist_ce_n[14], hist_ce_n[15]}), 32'b01);

      // Write 0x000AAA sel 0011 -> word 0x555 gets 0x00AA
      applyStimulus(24'h000AAA, 32'h000000AA, 4'b0011, 1'b1, 0, 12);
      checkOutput("wr_ack_cycle", 32'(ack_cycle), 32'd6);
      checkOutput("wr_ack_count", 32'(ack_count), 32'd1);
      checkOutput("wr_addr", 32'(hist_addr[2]), 32'h555);
      checkOutput("wr_dq", 32'(hist_dq_o[2]), 32'h00AA);
      checkOutput("wr_we_low", 32'(we_low), 32'd3);
      checkOutput("wr_we_window", 32'({hist_we_n[1], hist_we_n[2], hist_we_n[4], hist_we_n[5]}), 32'b1001);
      checkOutput("wr_ce_low", 32'(ce_low), 32'd5);
      checkOutput("wr_oe_low", 32'(oe_low), 32'd0);
      checkOutput("wr_dq_oe", 32'({hist_dq_oe[1], hist_dq_oe[5], hist_dq_oe[6]}), 32'b110);

      // Write sel 1111 -> error, no flash activity
      applyStimulus(24'h000020, 32'hDEADBEEF, 4'b1111, 1'b1, 0, 8);
      checkOutput("bad_err_cycle", 32'(err_cycle), 32'd1);
      checkOutput("bad_err_count", 32'(err_count), 32'd1);
      checkOutput("bad_ack_count", 32'(ack_count), 32'd0);
      checkOutput("bad_strobes", 32'(ce_low + we_low), 32'd0);

      // Status register with flash busy, then ready
      applyStimulus(24'h800000, 32'h0, 4'b1111, 1'b0, 0, 4);
      checkOutput("st_busy_ack", 32'(ack_cycle), 32'd1);
      checkOutput("st_busy_dat", got_dat, 32'h00000000);
      flash_ry = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(24'h800000, 32'h0, 4'b1111, 1'b0, 0, 4);
      checkOutput("st_ready_ack", 32'(ack_cycle), 32'd1);
      checkOutput("st_ready_dat", got_dat, 32'h00000001);

      // cyc dropped in RD_LO: flash read finishes, no termination
      applyStimulus(24'h000010, 32'h0, 4'b1111, 1'b0, 10, 20);
      checkOutput("drop_ack_count", 32'(ack_count + err_count), 32'd0);
      checkOutput("drop_addr_lo", 32'(hist_addr[14]), 32'd9);
      checkOutput("drop_oe_end", 32'({hist_oe_n[14], hist_oe_n[15]}), 32'b01);

      // Following read 0x000014 -> words 10,11
      applyStimulus(24'h000014, 32'h0, 4'b1111, 1'b0, 0, 20);
      checkOutput("rd2_ack_cycle", 32'(ack_cycle), 32'd15);
      checkOutput("rd2_data", got_dat, 32'hC00AC00B);

      // Reset in the middle of a write pulse
      @(negedge clk);
      wb_adr_i = 24'h000AAA; wb_dat_i = 32'h000000AA;
      wb_sel_i = 4'b0011; wb_we_i = 1'b1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("mid_we_low", 32'(flash_we_n), 32'd0);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_pins",
                  32'({flash_reset_n, flash_ce_n, flash_oe_n, flash_we_n, flash_dq_oe, wb_ack_o, wb_err_o}),
                  32'b0111000);
      checkOutput("mid_rst_addr", 32'(flash_addr), 32'd0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ack_count = 0;
      for (int k = 1; k <= 26; k++) begin
         @(negedge clk);
         if (wb_ack_o || wb_err_o) ack_count++;
      end
      checkOutput("mid_no_ack", 32'(ack_count), 32'd0);
      checkOutput("mid_release", 32'(flash_reset_n), 32'd1);

      checkOutput("oe_we_overlap", 32'(overlap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/flash_wb_ctrl.md
FLASH_WB_CTRL -- requirements
Module: flash_wb_ctrl

Interface
REQ-001 Parameter RD_WAIT, default 7, cycles per 16-bit read access (7 cycles = 140 ns at 50 MHz); legal range 2..31.
REQ-002 Parameter WE_PULSE, default 3, cycles flash_we_n held low per write; legal range 1..15.
REQ-003 Parameter RST_CYCLES, default 25, cycles flash_reset_n held low after rst release; legal range 1..255.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wb_adr_i  in  24  byte address; [22:2] selects a 32-bit flash word, [23]=1 selects the status register.
REQ-007 wb_dat_i  in  32  write data; wb_dat_o  out  32  read data.
REQ-008 wb_sel_i  in  4  byte lanes; wb_we_i, wb_cyc_i, wb_stb_i  in  1  Wishbone classic controls.
REQ-009 wb_ack_o, wb_err_o  out  1  single-cycle termination pulses.
REQ-010 flash_addr  out  22  16-bit word address to flash.
REQ-011 flash_dq_i  in  16; flash_dq_o  out  16; flash_dq_oe  out  1  tristate enable, resolved at chip top.
REQ-012 flash_ce_n, flash_oe_n, flash_we_n, flash_reset_n  out  1  active-low flash strobes.
REQ-013 flash_wp_n, flash_byte_n  out  1  tied to 1 (word mode, no write protect).
REQ-014 flash_ry  in  1  asynchronous ready/busy from flash, 1 = ready.

Function
REQ-015 FSM states: RST_HOLD, IDLE, RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-016 A request is accepted in IDLE when wb_cyc_i & wb_stb_i are both 1; the address, data, sel and we are registered on that edge.
REQ-017 Read: RD_HI drives flash_addr={adr[22:2],0}, ce_n=oe_n=0 for RD_WAIT cycles and captures flash_dq_i into wb_dat_o[31:16] on its final edge; RD_LO repeats at {adr[22:2],1} into [15:0] (big-endian).
REQ-018 Read wb_ack_o is high exactly 2*RD_WAIT+1 cycles after the accepting edge (15 cycles at default), for one cycle.
REQ-019 Write: legal only with sel=4'b1100 (data [31:16] to word {adr[22:2],0}) or sel=4'b0011 (data [15:0] to word {adr[22:2],1}).
REQ-020 Write sequence: WR_SETUP 1 cycle (ce_n=0, dq_oe=1, addr/data valid), WR_PULSE WE_PULSE cycles (we_n=0), WR_HOLD 1 cycle (we_n=1, dq_oe=1); ack follows in DONE.
REQ-021 Write with any other sel: no flash strobe, wb_err_o pulses 1 cycle after acceptance.
REQ-022 Status read (adr[23]=1): returns {31'b0, ry_sync}; ack 1 cycle after acceptance; status write is acked with no effect.
REQ-023 flash_ry passes a 2-flop synchronizer before use; the controller never waits on it.
REQ-024 oe_n and we_n are never low simultaneously; dq_oe=1 only in WR_* states.
REQ-025 DONE lasts 1 cycle, then IDLE; a stb still high in the cycle after ack is a new request.
REQ-026 wb_cyc_i dropped mid-access: the current flash access completes, ack/err are suppressed, FSM returns to IDLE.
REQ-027 Requests arriving during RST_HOLD are held un-acked until IDLE.

Reset
REQ-028 On rst: FSM=RST_HOLD, flash_reset_n=0, ce_n=oe_n=we_n=1, dq_oe=0, flash_addr=0, wb_dat_o=0, ack=err=0, synchronizer=0.
REQ-029 After rst deasserts, RST_HOLD persists RST_CYCLES cycles, then flash_reset_n=1 and FSM=IDLE.
REQ-030 rst asserted mid-access aborts immediately to reset values; no ack is issued.

Structure
REQ-031 Shared package flash_ctrl_pkg holds state encoding and default timing constants (RD_WAIT, WE_PULSE, RST_CYCLES).
REQ-032 One sub-module: flash_ry_sync (2-flop synchronizer, async reset to 0); all else in one FSM with one shared down-counter.

Verification
REQ-033 Reset release -> flash_reset_n low exactly 25 cycles, then high; no strobes toggle meanwhile.
REQ-034 Read adr 0x000010, flash words 8=0x1234, 9=0xABCD -> wb_dat_o=0x1234ABCD, ack at cycle 15 after accept.
REQ-035 Write adr 0x000AAA sel=0011 data 0x000000AA -> flash_addr=0x555, dq=0x00AA, we_n low 3 cycles; ack 1 cycle after WR_HOLD.
REQ-036 Write sel=1111 -> err pulse 1 cycle after acceptance, ce_n/we_n stay high, no ack.
REQ-037 flash_ry=0 then status read at 0x800000 -> 0x00000000; flash_ry=1 held 3 cycles, reread -> 0x00000001.
REQ-038 Drop cyc during RD_LO -> read completes on flash pins, no ack; next read acks normally.
